// File: rtl/car_traffic_controller_pkg.sv
// rtl/car_traffic_controller_pkg.sv - shared screen, lane and position constants for road traffic
package car_traffic_controller_pkg;

   localparam int TILE_SIZE    = 16;
   localparam int SCREEN_WIDTH = 640;
   localparam int POS_W        = 10;
   localparam int PERIOD_W     = 20;
   localparam int NUM_LANES    = 4;

   typedef enum logic {
      DIR_RIGHT = 1'b0,
      DIR_LEFT  = 1'b1
   } dir_e;

   // Lane table: row in tiles, travel direction, pixels per step, spawn column in tiles
   localparam int   LANE_ROW         [NUM_LANES] = '{10, 12, 14, 16};
   localparam dir_e LANE_DIR         [NUM_LANES] = '{DIR_RIGHT, DIR_LEFT, DIR_RIGHT, DIR_LEFT};
   localparam int   LANE_STEP        [NUM_LANES] = '{1, 1, 2, 2};
   localparam int   LANE_SPAWN_TILES [NUM_LANES] = '{8, 24, 0, 32};

   // Step period for a level, floored at min_p; a reduction past base clamps instead of wrapping
   function automatic logic [PERIOD_W-1:0] compute_period(
      input logic [2:0] level,
      input int         base_p,
      input int         step_p,
      input int         min_p
   );
      logic [PERIOD_W-1:0] w_base;
      logic [PERIOD_W-1:0] w_red;
      logic [PERIOD_W-1:0] w_min;
      w_base = PERIOD_W'(base_p);
      w_min  = PERIOD_W'(min_p);
      w_red  = PERIOD_W'(level) * PERIOD_W'(step_p);
      if ((w_red >= w_base) || ((w_base - w_red) < w_min)) begin
         compute_period = w_min;
      end else begin
         compute_period = w_base - w_red;
      end
   endfunction

endpackage

// File: rtl/car_traffic_controller_if.sv
// rtl/car_traffic_controller_if.sv - car-position bus between traffic producer and its consumers
interface car_traffic_controller_if;
   import car_traffic_controller_pkg::*;

   logic             i_Run;
   logic             i_Restart;
   logic [2:0]       i_Level;
   logic [POS_W-1:0] o_Car0_X;
   logic [POS_W-1:0] o_Car1_X;
   logic [POS_W-1:0] o_Car2_X;
   logic [POS_W-1:0] o_Car3_X;
   logic [POS_W-1:0] o_Car0_Y;
   logic [POS_W-1:0] o_Car1_Y;
   logic [POS_W-1:0] o_Car2_Y;
   logic [POS_W-1:0] o_Car3_Y;
   logic             o_Tick;

   modport master (
      input  i_Run, i_Restart, i_Level,
      output o_Car0_X, o_Car1_X, o_Car2_X, o_Car3_X,
      output o_Car0_Y, o_Car1_Y, o_Car2_Y, o_Car3_Y,
      output o_Tick
   );

   modport slave (
      output i_Run, i_Restart, i_Level,
      input  o_Car0_X, o_Car1_X, o_Car2_X, o_Car3_X,
      input  o_Car0_Y, o_Car1_Y, o_Car2_Y, o_Car3_Y,
      input  o_Tick
   );

endinterface

// File: rtl/car_traffic_controller_car_lane.sv
// rtl/car_traffic_controller_car_lane.sv - one lane's X register with horizontal wrap
module car_lane
   import car_traffic_controller_pkg::*;
#(
   parameter dir_e DIRECTION    = DIR_RIGHT,
   parameter int   STEP         = 1,
   parameter int   SPAWN_X      = 0,
   parameter int   SCREEN_WIDTH = car_traffic_controller_pkg::SCREEN_WIDTH
) (
   input  logic             i_Clk,
   input  logic             i_Reset,
   input  logic             i_Restart,
   input  logic             i_Advance,
   output logic [POS_W-1:0] o_X
);

   localparam logic [10:0]      STEP_W  = 11'(STEP);
   localparam logic [10:0]      WIDTH_W = 11'(SCREEN_WIDTH);
   localparam logic [POS_W-1:0] SPAWN_W = POS_W'(SPAWN_X);

   logic [POS_W-1:0] r_x;
   logic [10:0]      w_x_ext;
   logic [10:0]      w_sum;
   logic [POS_W-1:0] w_next;

   // 11-bit intermediates keep X+STEP and X+WIDTH-STEP from overflowing
   always_comb begin
      w_x_ext = {1'b0, r_x};
      w_sum   = w_x_ext + STEP_W;
      w_next  = r_x;
      if (DIRECTION == DIR_RIGHT) begin
         if (w_sum >= WIDTH_W) begin
            w_next = POS_W'(w_sum - WIDTH_W);
         end else begin
            w_next = POS_W'(w_sum);
         end
      end else begin
         if (w_x_ext < STEP_W) begin
            w_next = POS_W'(w_x_ext + WIDTH_W - STEP_W);
         end else begin
            w_next = POS_W'(w_x_ext - STEP_W);
         end
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset || i_Restart) begin
         r_x <= SPAWN_W;
      end else if (i_Advance) begin
         r_x <= w_next;
      end
   end

   assign o_X = r_x;

endmodule

// File: rtl/car_traffic_controller.sv
// rtl/car_traffic_controller.sv - level-paced step tick driving four wrapping road lanes
module car_traffic_controller
   import car_traffic_controller_pkg::*;
#(
   parameter int TILE_SIZE    = car_traffic_controller_pkg::TILE_SIZE,
   parameter int SCREEN_WIDTH = car_traffic_controller_pkg::SCREEN_WIDTH,
   parameter int BASE_PERIOD  = 250000,
   parameter int PERIOD_STEP  = 25000,
   parameter int MIN_PERIOD   = 50000
) (
   input logic                       i_Clk,
   input logic                       i_Reset,
   car_traffic_controller_if.master  bus
);

   logic [PERIOD_W-1:0] w_period;
   logic [PERIOD_W-1:0] r_period;
   logic [PERIOD_W-1:0] r_count;
   logic                r_tick;
   logic                w_advance;
   logic [POS_W-1:0]    w_car_x [NUM_LANES];

   assign w_period  = compute_period(bus.i_Level, BASE_PERIOD, PERIOD_STEP, MIN_PERIOD);
   assign w_advance = bus.i_Run && (r_count == (r_period - PERIOD_W'(1)));

   // Period is relatched only at reset/restart/tick so a running period is never cut short
   always_ff @(posedge i_Clk) begin
      if (i_Reset || bus.i_Restart) begin
         r_count  <= '0;
         r_period <= w_period;
         r_tick   <= 1'b0;
      end else if (w_advance) begin
         r_count  <= '0;
         r_period <= w_period;
         r_tick   <= 1'b1;
      end else begin
         if (bus.i_Run) begin
            r_count <= r_count + PERIOD_W'(1);
         end
         r_tick <= 1'b0;
      end
   end

   genvar g;
   generate
      for (g = 0; g < NUM_LANES; g++) begin : g_lane
         car_lane #(
            .DIRECTION    (LANE_DIR[g]),
            .STEP         (LANE_STEP[g]),
            .SPAWN_X      (LANE_SPAWN_TILES[g] * TILE_SIZE),
            .SCREEN_WIDTH (SCREEN_WIDTH)
         ) u_lane (
            .i_Clk     (i_Clk),
            .i_Reset   (i_Reset),
            .i_Restart (bus.i_Restart),
            .i_Advance (w_advance),
            .o_X       (w_car_x[g])
         );
      end
   endgenerate

   assign bus.o_Car0_X = w_car_x[0];
   assign bus.o_Car1_X = w_car_x[1];
   assign bus.o_Car2_X = w_car_x[2];
   assign bus.o_Car3_X = w_car_x[3];

   assign bus.o_Car0_Y = POS_W'(LANE_ROW[0] * TILE_SIZE);
   assign bus.o_Car1_Y = POS_W'(LANE_ROW[1] * TILE_SIZE);
   assign bus.o_Car2_Y = POS_W'(LANE_ROW[2] * TILE_SIZE);
   assign bus.o_Car3_Y = POS_W'(LANE_ROW[3] * TILE_SIZE);

   assign bus.o_Tick = r_tick;

endmodule

// File: tb/tb_car_traffic_controller.sv
// tb/tb_car_traffic_controller.sv - scoreboard bench for car_traffic_controller
module tb_car_traffic_controller;

   typedef struct packed {
      logic       tick;
      logic [9:0] x0;
      logic [9:0] x1;
      logic [9:0] x2;
      logic [9:0] x3;
   } exp_t;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;
   int   cyc;
   exp_t sb [$];

   int m_x [4];
   int m_cnt;
   int m_per;
   int spawn_x [4] = '{128, 384, 0, 512};
   int dstep   [4] = '{1, -1, 2, -2};

   car_traffic_controller_if ifc ();

   car_traffic_controller #(
      .TILE_SIZE    (16),
      .SCREEN_WIDTH (640),
      .BASE_PERIOD  (10),
      .PERIOD_STEP  (2),
      .MIN_PERIOD   (4)
   ) dut (
      .i_Clk   (clk),
      .i_Reset (rst),
      .bus     (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
      end
   endtask

   function automatic int model_period(input int lvl);
      int p;
      p = 10 - lvl * 2;
      if (p < 4) p = 4;
      return p;
   endfunction

   task automatic step(input bit r, input bit rs, input bit run, input int lvl);
      exp_t e;
      exp_t got;
      rst           = r;
      ifc.i_Restart = rs;
      ifc.i_Run     = run;
      ifc.i_Level   = 3'(lvl);
      e.tick = 1'b0;
      if (r || rs) begin
         for (int i = 0; i < 4; i++) m_x[i] = spawn_x[i];
         m_cnt = 0;
         m_per = model_period(lvl);
      end else if (run && (m_cnt == m_per - 1)) begin
         for (int i = 0; i < 4; i++) m_x[i] = ((m_x[i] + dstep[i]) % 640 + 640) % 640;
         m_cnt  = 0;
         m_per  = model_period(lvl);
         e.tick = 1'b1;
      end else if (run) begin
         m_cnt++;
      end
      e.x0 = 10'(m_x[0]);
      e.x1 = 10'(m_x[1]);
      e.x2 = 10'(m_x[2]);
      e.x3 = 10'(m_x[3]);
      sb.push_back(e);
      @(posedge clk);
      #1;
      cyc++;
      got = {ifc.o_Tick, ifc.o_Car0_X, ifc.o_Car1_X, ifc.o_Car2_X, ifc.o_Car3_X};
      if (sb.size() == 0) begin
         check_val("sb_empty", 0, 1);
      end else begin
         e = sb.pop_front();
         check_val("tick", int'(got.tick), int'(e.tick));
         check_val("x0", int'(got.x0), int'(e.x0));
         check_val("x1", int'(got.x1), int'(e.x1));
         check_val("x2", int'(got.x2), int'(e.x2));
         check_val("x3", int'(got.x3), int'(e.x3));
      end
   endtask

   task automatic run_until_tick(input int maxc, input int lvl, output int n);
      n = 0;
      do begin
         step(1'b0, 1'b0, 1'b1, lvl);
         n++;
      end while (!ifc.o_Tick && n < maxc);
   endtask

   task automatic check_spawn(input string tag);
      check_val({tag, "_x0"}, int'(ifc.o_Car0_X), 128);
      check_val({tag, "_x1"}, int'(ifc.o_Car1_X), 384);
      check_val({tag, "_x2"}, int'(ifc.o_Car2_X), 0);
      check_val({tag, "_x3"}, int'(ifc.o_Car3_X), 512);
      check_val({tag, "_tick"}, int'(ifc.o_Tick), 0);
   endtask

   initial begin
      int n;
      int tick_at [$];
      int held [4];
      n_cmp = 0;
      n_bad = 0;
      cyc   = 0;
      rst   = 1'b1;
      ifc.i_Run = 1'b0;
      ifc.i_Restart = 1'b0;
      ifc.i_Level = 3'd0;

      step(1'b1, 1'b0, 1'b0, 0);
      step(1'b1, 1'b0, 1'b0, 0);
      check_spawn("reset");
      check_val("y0", int'(ifc.o_Car0_Y), 160);
      check_val("y1", int'(ifc.o_Car1_Y), 192);
      check_val("y2", int'(ifc.o_Car2_Y), 224);
      check_val("y3", int'(ifc.o_Car3_Y), 256);

      for (int e = 1; e <= 30; e++) begin
         step(1'b0, 1'b0, 1'b1, 0);
         if (ifc.o_Tick) tick_at.push_back(e);
         if (e == 10) begin
            check_val("first_x0", int'(ifc.o_Car0_X), 129);
            check_val("first_x1", int'(ifc.o_Car1_X), 383);
            check_val("first_x2", int'(ifc.o_Car2_X), 2);
            check_val("first_x3", int'(ifc.o_Car3_X), 510);
         end
      end
      check_val("tick_count", tick_at.size(), 3);
      for (int i = 0; i < tick_at.size() && i < 3; i++) check_val("tick_edge", tick_at[i], 10 * (i + 1));

      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 0);
      run_until_tick(30, 5, n);
      check_val("lvl_change_old_period", n, 7);
      run_until_tick(30, 5, n);
      check_val("lvl5_period", n, 4);
      run_until_tick(30, 7, n);
      check_val("lvl7_clamp", n, 4);

      step(1'b0, 1'b1, 1'b1, 7);
      check_spawn("restart_pre_wrap");
      for (int t = 1; t <= 512; t++) begin
         run_until_tick(20, 7, n);
         check_val("wrap_period", n, 4);
         if (t == 256) check_val("l3_at_0", int'(ifc.o_Car3_X), 0);
         if (t == 257) check_val("l3_wrap", int'(ifc.o_Car3_X), 638);
         if (t == 319) check_val("l2_at_638", int'(ifc.o_Car2_X), 638);
         if (t == 320) check_val("l2_wrap", int'(ifc.o_Car2_X), 0);
         if (t == 511) check_val("l0_at_639", int'(ifc.o_Car0_X), 639);
         if (t == 512) check_val("l0_wrap", int'(ifc.o_Car0_X), 0);
      end

      step(1'b0, 1'b0, 1'b1, 7);
      step(1'b0, 1'b0, 1'b1, 7);
      held = '{int'(ifc.o_Car0_X), int'(ifc.o_Car1_X), int'(ifc.o_Car2_X), int'(ifc.o_Car3_X)};
      for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, 7);
      check_val("pause_x0", int'(ifc.o_Car0_X), held[0]);
      check_val("pause_x3", int'(ifc.o_Car3_X), held[3]);
      run_until_tick(20, 7, n);
      check_val("pause_interval", 2 + 7 + n, 11);

      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 7);
      step(1'b0, 1'b1, 1'b1, 7);
      check_spawn("restart_on_tick");
      run_until_tick(20, 7, n);
      check_val("restart_next_tick", n, 4);

      step(1'b1, 1'b1, 1'b1, 0);
      check_spawn("reset_restart");
      run_until_tick(30, 0, n);
      check_val("reset_period", n, 10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/car_traffic_controller.md
# car_traffic_controller

Generates the positions of the four road cars. It is the producer side of the car-position interface that the sprite renderer and the collision checker consume, and it replaces the constant car coordinates currently tied off at the game top level. Cars advance on a frame-independent step tick whose period shrinks as the level rises. Positions wrap horizontally and return to spawn on restart.

## Interface
Parameters:
- TILE_SIZE, 16: pixels per tile.
- SCREEN_WIDTH, 640: horizontal wrap modulus in pixels.
- BASE_PERIOD, 250000: step period at level 0, in clocks (10 ms at 25 MHz).
- PERIOD_STEP, 25000: period reduction per level.
- MIN_PERIOD, 50000: floor on the step period.

Ports:
- i_Clk  in  1  system clock; the only clock.
- i_Reset  in  1  reset, synchronous and active-high.
- i_Run  in  1  high = traffic moves; low = freeze counter and positions.
- i_Restart  in  1  one-cycle pulse; returns cars to spawn (driven from collision or game-over).
- i_Level  in  3  difficulty level, 0..7.
- o_Car0_X, o_Car1_X, o_Car2_X, o_Car3_X  out  10 each  car pixel X, range 0..SCREEN_WIDTH-1.
- o_Car0_Y, o_Car1_Y, o_Car2_Y, o_Car3_Y  out  10 each  car pixel Y, constant per lane.
- o_Tick  out  1  one-cycle pulse on the edge where positions advance.

## Operation
- Lane table (lane: row, direction, pixels per step, spawn X):
  - lane 0: row 10, right, 1, 8*TILE_SIZE.
  - lane 1: row 12, left, 1, 24*TILE_SIZE.
  - lane 2: row 14, right, 2, 0.
  - lane 3: row 16, left, 2, 32*TILE_SIZE.
- Y = row*TILE_SIZE. It is a constant, so it is unaffected by reset, restart or run.
- Period P = max(MIN_PERIOD, BASE_PERIOD - i_Level*PERIOD_STEP).
  - Compute it in 20-bit unsigned arithmetic.
  - Clamp when the subtraction would go negative.
- Period register and tick counter:
  - P is latched into the period register at reset, at restart, and on every tick edge.
  - A level change therefore takes effect from the next period. The running period is never shortened.
  - The counter increments on each cycle with i_Run=1.
  - When counter == P_reg-1 and i_Run=1, the counter goes to 0, every lane advances by its step and o_Tick=1 for that cycle.
- Right wrap: X_next = X+s, minus SCREEN_WIDTH if X+s >= SCREEN_WIDTH.
- Left wrap: X_next = X-s, plus SCREEN_WIDTH if X < s.
- Use 11-bit intermediates so there is no overflow.
- Priority: i_Reset > i_Restart > tick > hold.
  - Restart coinciding with a tick: cars go to spawn, no advance, o_Tick=0, counter=0.
- i_Run low: counter, positions and period register all hold, and o_Tick=0. Restart still acts while paused.

## Timing
- Reset (and restart): all X outputs go to spawn, counter=0, o_Tick=0, period register = P computed from the current i_Level.
- All outputs are registered. No combinational path from any input to any output.
- With i_Run held high from the first post-reset cycle, the first advance and o_Tick appear after exactly P_reg rising edges. Advances then repeat every P_reg edges.
- Reset or restart mid-period discards the partial count.
- Outputs change only on tick, restart or reset edges. Consumers may sample them at any time; no handshake is needed.

## Structure
- Constants.v (shared) holds:
  - TILE_SIZE and SCREEN_WIDTH.
  - The lane row, direction, step and spawn constants.
  - The 10-bit position width.
- car_traffic_controller contains:
  - the period computation;
  - the tick counter;
  - four instances of sub-module car_lane.
- car_lane is parameterised by DIRECTION, STEP and SPAWN_X.
  - It holds one X register.
  - It has inputs i_Clk, i_Reset, i_Restart, i_Advance and output o_X.
  - It implements the wrap arithmetic.

## Test plan
Use BASE_PERIOD=10, PERIOD_STEP=2, MIN_PERIOD=4 unless noted.
- Reset check: pulse i_Reset, i_Level=0 → X = 128/384/0/512; Y = 160/192/224/256; o_Tick=0.
- Period check: i_Run=1, level 0 → o_Tick on edge 10, 20, 30. After the first tick, lane 0 = 129, lane 1 = 383, lane 2 = 2, lane 3 = 510.
- Level change and clamp: set i_Level=5 mid-period → current period stays 10, later periods are 4. i_Level=7 → 4, not negative.
- Wrap: run 511 ticks → lane 0 = 639; the next tick gives lane 0 = 0. Lane 3 after 256 ticks = 0; the next tick gives 638. Lane 2 at 638 wraps to 0.
- Pause: drop i_Run for 7 cycles mid-period → the tick is delayed by exactly 7 cycles and positions are unchanged while paused.
- Restart: i_Restart on the same cycle as a due tick → spawn values, o_Tick=0, the next tick P_reg edges later. i_Reset together with i_Restart → reset values.
